// File: rtl/btn_conditioner.sv
// Button front end: two-flop synchronizer and debounce on all four buttons,
// plus a long-hold qualifier on the reset and test channels. All levels are active-low.

module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level_n
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize, then accept a new level only after it has been stable long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level_n <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= raw_n;
      sync_q2 <= sync_q1;
      if (sync_q2 == level_n) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_n <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

module btn_hold #(
  parameter int unsigned HOLD_CYCLES = 250000000
) (
  input  logic clk,
  input  logic rst,
  input  logic level_n,
  output logic hold_n
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt_q;

  // Count consecutive low cycles; saturate at the threshold so the output holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      hold_n     <= 1'b1;
    end else if (level_n) begin
      hold_cnt_q <= '0;
      hold_n     <= 1'b1;
    end else if (hold_cnt_q == HOLD_MAX) begin
      hold_n <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      hold_n     <= 1'b1;
    end
  end

endmodule

module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 250000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_heal_n,
  input  logic btn_ali_n,
  input  logic btn_rst_n,
  input  logic btn_tst_n,
  output logic heal_n,
  output logic ali_n,
  output logic rst_hold_n,
  output logic tst_hold_n
);

  logic rst_level_n;
  logic tst_level_n;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_heal (
    .clk(clk), .rst(rst), .raw_n(btn_heal_n), .level_n(heal_n)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ali (
    .clk(clk), .rst(rst), .raw_n(btn_ali_n), .level_n(ali_n)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk(clk), .rst(rst), .raw_n(btn_rst_n), .level_n(rst_level_n)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tst (
    .clk(clk), .rst(rst), .raw_n(btn_tst_n), .level_n(tst_level_n)
  );

  // Mode buttons only assert after a sustained debounced press.
  btn_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_rst (
    .clk(clk), .rst(rst), .level_n(rst_level_n), .hold_n(rst_hold_n)
  );

  btn_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_tst (
    .clk(clk), .rst(rst), .level_n(tst_level_n), .hold_n(tst_hold_n)
  );

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// Outputs are packed as {heal_n, ali_n, rst_hold_n, tst_hold_n} and sampled 1 time unit after each rising edge.

module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn_heal_n, btn_ali_n, btn_rst_n, btn_tst_n;
  logic heal_n, ali_n, rst_hold_n, tst_hold_n;

  int total = 0;
  int bad   = 0;

  btn_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .btn_heal_n(btn_heal_n), .btn_ali_n(btn_ali_n),
    .btn_rst_n(btn_rst_n), .btn_tst_n(btn_tst_n),
    .heal_n(heal_n), .ali_n(ali_n),
    .rst_hold_n(rst_hold_n), .tst_hold_n(tst_hold_n)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {heal_n, ali_n, rst_hold_n, tst_hold_n};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    btn_heal_n = 1'b1; btn_ali_n = 1'b1; btn_rst_n = 1'b1; btn_tst_n = 1'b1;

    // 1. async reset between edges, then idle
    #2 rst = 1'b1;
    #1 chk("reset_async", 32'(outs()), 32'hF);
    step(2);
    #2 rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("idle", 32'(outs()), 32'hF);
    end

    // 2. clean heal press and release
    btn_heal_n = 1'b0;
    step(5);
    chk("heal_press_e5", 32'(outs()), 32'hF);
    step(1);
    chk("heal_press_e6", 32'(outs()), 32'h7);
    step(10);
    chk("heal_held", 32'(outs()), 32'h7);
    btn_heal_n = 1'b1;
    step(5);
    chk("heal_rel_e5", 32'(outs()), 32'h7);
    step(1);
    chk("heal_rel_e6", 32'(outs()), 32'hF);

    // 3. bounce rejection on feed: 3-low / 3-high pulses
    for (int i = 0; i < 42; i++) begin
      btn_ali_n = ((i % 6) < 3) ? 1'b0 : 1'b1;
      step(1);
      chk("ali_bounce", 32'(ali_n), 32'h1);
    end
    btn_ali_n = 1'b0;
    step(5);
    chk("ali_final_e5", 32'(outs()), 32'hF);
    step(1);
    chk("ali_final_e6", 32'(outs()), 32'hB);
    btn_ali_n = 1'b1;
    step(6);
    chk("ali_rel", 32'(outs()), 32'hF);

    // 4. long hold on reset button
    btn_rst_n = 1'b0;
    step(15);
    chk("rst_hold_e15", 32'(rst_hold_n), 32'h1);
    step(1);
    chk("rst_hold_e16", 32'(rst_hold_n), 32'h1);
    step(1);
    chk("rst_hold_e17", 32'(outs()), 32'hD);
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("rst_hold_keep", 32'(rst_hold_n), 32'h0);
    end
    btn_rst_n = 1'b1;
    step(6);
    chk("rst_rel_e6", 32'(rst_hold_n), 32'h0);
    step(1);
    chk("rst_rel_e7", 32'(outs()), 32'hF);

    // 5. short hold: 10 raw-low cycles stays one cycle short of the threshold
    btn_tst_n = 1'b0;
    step(10);
    btn_tst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("tst_short", 32'(tst_hold_n), 32'h1);
    end
    btn_tst_n = 1'b0;
    step(16);
    chk("tst_again_e16", 32'(tst_hold_n), 32'h1);
    step(1);
    chk("tst_again_e17", 32'(outs()), 32'hE);
    btn_tst_n = 1'b1;
    step(7);
    chk("tst_rel", 32'(outs()), 32'hF);

    // 6. all four together, reset mid-hold, latencies re-incurred
    btn_heal_n = 1'b0; btn_ali_n = 1'b0; btn_rst_n = 1'b0; btn_tst_n = 1'b0;
    step(5);
    chk("all_e5", 32'(outs()), 32'hF);
    step(1);
    chk("all_e6", 32'(outs()), 32'h3);
    step(10);
    chk("all_e16", 32'(outs()), 32'h3);
    step(1);
    chk("all_e17", 32'(outs()), 32'h0);
    step(5);
    #3 rst = 1'b1;
    #1 chk("mid_reset", 32'(outs()), 32'hF);
    step(2);
    chk("in_reset", 32'(outs()), 32'hF);
    #2 rst = 1'b0;
    step(5);
    chk("post_rst_e5", 32'(outs()), 32'hF);
    step(1);
    chk("post_rst_e6", 32'(outs()), 32'h3);
    step(10);
    chk("post_rst_e16", 32'(outs()), 32'h3);
    step(1);
    chk("post_rst_e17", 32'(outs()), 32'h0);
    btn_heal_n = 1'b1; btn_ali_n = 1'b1; btn_rst_n = 1'b1; btn_tst_n = 1'b1;
    step(6);
    chk("all_rel_e6", 32'(outs()), 32'hC);
    step(1);
    chk("all_rel_e7", 32'(outs()), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
